// File: rtl/decstage_pkg.sv
// rtl/decstage_pkg.sv - shared constants for the decode stage
package decstage_pkg;

  typedef enum logic [1:0] {
    IMM_SIGN = 2'b00,
    IMM_ZERO = 2'b01,
    IMM_HI16 = 2'b10,
    IMM_BR   = 2'b11
  } imm_sel_e;

  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int RS_LSB  = 21;
  localparam int RD_LSB  = 16;
  localparam int RT_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  localparam logic [OPC_W-1:0] DEF_LOAD_OPC = 6'b001111;

endpackage

// File: rtl/decstage_pipe_regfile_bypass.sv
// rtl/decstage_pipe_regfile_bypass.sv - 2R1W register file, R0 tied to 0, write-through bypass
module regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int REG_CNT = 32,
  localparam int ADDR_W = $clog2(REG_CNT)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_rd_a_addr,
  input  logic [ADDR_W-1:0] i_rd_b_addr,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b
);

  logic [DATA_W-1:0] r_mem [REG_CNT];
  logic              w_wr_live;

  assign w_wr_live = i_wr_en && (i_wr_addr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_CNT; i++) r_mem[i] <= '0;
    end else if (w_wr_live) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // A write in flight wins over the array so a reader sees it in the same cycle.
  assign o_rd_a = (i_rd_a_addr == '0) ? '0 :
                  (w_wr_live && i_rd_a_addr == i_wr_addr) ? i_wr_data : r_mem[i_rd_a_addr];
  assign o_rd_b = (i_rd_b_addr == '0) ? '0 :
                  (w_wr_live && i_rd_b_addr == i_wr_addr) ? i_wr_data : r_mem[i_rd_b_addr];

endmodule

// File: rtl/decstage_pipe.sv
// rtl/decstage_pipe.sv - decode stage: register read, immediate generation, load-use hazard, ID/EX register
module decstage_pipe
  import decstage_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                REG_CNT  = 32,
  parameter logic [OPC_W-1:0]  LOAD_OPC = DEF_LOAD_OPC,
  localparam int               ADDR_W   = $clog2(REG_CNT)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [31:0]       Instr,
  input  logic              Instr_valid,
  input  logic [1:0]        Imm_sel,
  input  logic              RF_B_sel,
  input  logic              Stall_in,
  input  logic              Flush,
  input  logic              RF_WrEn,
  input  logic [ADDR_W-1:0] Wb_Addr,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] MEM_out,
  input  logic              RF_WrData_sel,
  output logic [DATA_W-1:0] Immed,
  output logic [DATA_W-1:0] RF_A,
  output logic [DATA_W-1:0] RF_B,
  output logic [ADDR_W-1:0] Out_Rd,
  output logic              Out_valid,
  output logic              Out_IsLoad,
  output logic              Dec_stall
);

  logic [OPC_W-1:0]  w_opc;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_bsrc;
  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_wb_data;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_immed;
  logic              w_haz;

  assign w_opc  = Instr[OPC_LSB +: OPC_W];
  assign w_rs   = Instr[RS_LSB +: ADDR_W];
  assign w_rd   = Instr[RD_LSB +: ADDR_W];
  assign w_rt   = Instr[RT_LSB +: ADDR_W];
  assign w_imm  = Instr[IMM_LSB +: IMM_W];
  assign w_bsrc = RF_B_sel ? w_rd : w_rt;

  assign w_wb_data = RF_WrData_sel ? MEM_out : ALU_out;

  regfile_bypass #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_rf (
    .i_clk       (Clk),
    .i_rst_n     (Rst_n),
    .i_rd_a_addr (w_rs),
    .i_rd_b_addr (w_bsrc),
    .i_wr_en     (RF_WrEn),
    .i_wr_addr   (Wb_Addr),
    .i_wr_data   (w_wb_data),
    .o_rd_a      (w_rd_a),
    .o_rd_b      (w_rd_b)
  );

  assign w_sext = DATA_W'($signed(w_imm));

  always_comb begin
    w_immed = w_sext;
    case (imm_sel_e'(Imm_sel))
      IMM_SIGN: w_immed = w_sext;
      IMM_ZERO: w_immed = DATA_W'(w_imm);
      IMM_HI16: w_immed = DATA_W'($signed({w_imm, 16'h0000}));
      IMM_BR:   w_immed = w_sext << 2;
      default:  w_immed = w_sext;
    endcase
  end

  // Only a load still sitting in ID/EX can produce this hazard; its result is one cycle away.
  assign w_haz = Instr_valid && Out_valid && Out_IsLoad && (Out_Rd != '0) &&
                 ((w_rs == Out_Rd) || (w_bsrc == Out_Rd));

  assign Dec_stall = (w_haz || Stall_in) && !Flush;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Immed      <= '0;
      RF_A       <= '0;
      RF_B       <= '0;
      Out_Rd     <= '0;
      Out_valid  <= 1'b0;
      Out_IsLoad <= 1'b0;
    end else if (Flush) begin
      Immed      <= '0;
      RF_A       <= '0;
      RF_B       <= '0;
      Out_Rd     <= '0;
      Out_valid  <= 1'b0;
      Out_IsLoad <= 1'b0;
    end else if (Stall_in) begin
      Out_valid  <= Out_valid;
    end else if (w_haz) begin
      Out_valid  <= 1'b0;
      Out_IsLoad <= 1'b0;
    end else begin
      Immed      <= w_immed;
      RF_A       <= w_rd_a;
      RF_B       <= w_rd_b;
      Out_Rd     <= w_rd;
      Out_valid  <= Instr_valid;
      Out_IsLoad <= Instr_valid && (w_opc == LOAD_OPC);
    end
  end

endmodule

// File: tb/tb_decstage_pipe.sv
// tb/tb_decstage_pipe.sv - scoreboard bench for decstage_pipe
module tb_decstage_pipe;

  typedef struct packed {
    logic        v;
    logic        ld;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
  } idex_t;

  logic        Clk, Rst_n;
  logic [31:0] Instr;
  logic        Instr_valid, RF_B_sel, Stall_in, Flush, RF_WrEn, RF_WrData_sel;
  logic [1:0]  Imm_sel;
  logic [4:0]  Wb_Addr;
  logic [31:0] ALU_out, MEM_out;
  logic [31:0] Immed, RF_A, RF_B;
  logic [4:0]  Out_Rd;
  logic        Out_valid, Out_IsLoad, Dec_stall;

  int          n_checks, n_errors;
  idex_t       sb_q[$];
  idex_t       m_q;
  logic [31:0] m_rf [32];
  logic        s_stall;
  logic [31:0] imm_tbl [4];

  decstage_pipe dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .Instr_valid(Instr_valid),
    .Imm_sel(Imm_sel), .RF_B_sel(RF_B_sel), .Stall_in(Stall_in), .Flush(Flush),
    .RF_WrEn(RF_WrEn), .Wb_Addr(Wb_Addr), .ALU_out(ALU_out), .MEM_out(MEM_out),
    .RF_WrData_sel(RF_WrData_sel), .Immed(Immed), .RF_A(RF_A), .RF_B(RF_B),
    .Out_Rd(Out_Rd), .Out_valid(Out_valid), .Out_IsLoad(Out_IsLoad), .Dec_stall(Dec_stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, rd, rt);
    return {op, rs, rd, rt, 11'h000};
  endfunction

  function automatic logic [31:0] mki(input logic [5:0] op, input logic [4:0] rs, rd,
                                      input logic [15:0] im);
    return {op, rs, rd, im};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] ad);
    if (ad == 5'd0) return 32'h0;
    if (RF_WrEn && ad == Wb_Addr) return RF_WrData_sel ? MEM_out : ALU_out;
    return m_rf[ad];
  endfunction

  function automatic logic [31:0] m_imm(input logic [1:0] sel, input logic [15:0] i);
    case (sel)
      2'b00:   return {{16{i[15]}}, i};
      2'b01:   return {16'h0000, i};
      2'b10:   return {i, 16'h0000};
      default: return {{14{i[15]}}, i, 2'b00};
    endcase
  endfunction

  task automatic clear_in();
    Instr = 32'h0; Instr_valid = 1'b0; Imm_sel = 2'b00; RF_B_sel = 1'b0;
    Stall_in = 1'b0; Flush = 1'b0; RF_WrEn = 1'b0; Wb_Addr = 5'd0;
    ALU_out = 32'h0; MEM_out = 32'h0; RF_WrData_sel = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_q = '0;
  endtask

  // One clock: check Dec_stall, push the expected ID/EX state, then pop and compare after the edge.
  task automatic step();
    idex_t nx, e;
    logic [4:0] rs, rd, rt, bs;
    logic haz;
    @(negedge Clk);
    rs = Instr[25:21]; rd = Instr[20:16]; rt = Instr[15:11];
    bs = RF_B_sel ? rd : rt;
    haz = Instr_valid && m_q.v && m_q.ld && (m_q.rd != 5'd0) && (rs == m_q.rd || bs == m_q.rd);
    s_stall = Dec_stall;
    check("dec_stall", Dec_stall, (haz || Stall_in) && !Flush);
    if (Flush) nx = '0;
    else if (Stall_in) nx = m_q;
    else if (haz) begin
      nx = m_q; nx.v = 1'b0; nx.ld = 1'b0;
    end else begin
      nx.v   = Instr_valid;
      nx.ld  = Instr_valid && (Instr[31:26] == 6'h0F);
      nx.rd  = rd;
      nx.imm = m_imm(Imm_sel, Instr[15:0]);
      nx.a   = m_read(rs);
      nx.b   = m_read(bs);
    end
    sb_q.push_back(nx);
    @(posedge Clk);
    if (RF_WrEn && Wb_Addr != 5'd0) m_rf[Wb_Addr] = RF_WrData_sel ? MEM_out : ALU_out;
    m_q = nx;
    #1;
    e = sb_q.pop_front();
    check("out_valid", Out_valid, e.v);
    check("out_isload", Out_IsLoad, e.ld);
    check("out_rd", Out_Rd, e.rd);
    check("immed", Immed, e.imm);
    check("rf_a", RF_A, e.a);
    check("rf_b", RF_B, e.b);
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_valid"}, Out_valid, 0);
    check({tag, "_isload"}, Out_IsLoad, 0);
    check({tag, "_rd"}, Out_Rd, 0);
    check({tag, "_immed"}, Immed, 0);
    check({tag, "_a"}, RF_A, 0);
    check({tag, "_b"}, RF_B, 0);
    check({tag, "_stall"}, Dec_stall, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    imm_tbl[0] = 32'hFFFF8001; imm_tbl[1] = 32'h00008001;
    imm_tbl[2] = 32'h80010000; imm_tbl[3] = 32'hFFFE0004;
    clear_in();
    model_reset();
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_zero_outs("rst");
    Rst_n = 1'b1;

    // write R1 through the bypass, then read back from the array
    Instr = mk(6'h00, 5'd1, 5'd2, 5'd0); Instr_valid = 1'b1;
    RF_WrEn = 1'b1; Wb_Addr = 5'd1; ALU_out = 32'h3;
    step();
    check("byp_a", RF_A, 32'h3);
    RF_WrEn = 1'b0; ALU_out = 32'h0;
    step();
    check("arr_a", RF_A, 32'h3);

    Instr = mki(6'h00, 5'd0, 5'd0, 16'h8001);
    for (int s = 0; s < 4; s++) begin
      Imm_sel = 2'(s);
      step();
      check("imm_sweep", Immed, imm_tbl[s]);
    end
    Imm_sel = 2'b00;

    // load-use: one bubble, then the add picks up the MEM write-back via the bypass
    Instr = mki(6'h0F, 5'd1, 5'd3, 16'h0010);
    step();
    check("lu_isload", Out_IsLoad, 1);
    Instr = mk(6'h00, 5'd3, 5'd4, 5'd5);
    step();
    check("lu_stall", s_stall, 1);
    check("lu_bubble", Out_valid, 0);
    RF_WrEn = 1'b1; Wb_Addr = 5'd3; MEM_out = 32'h6; RF_WrData_sel = 1'b1;
    step();
    check("lu_stall_clr", s_stall, 0);
    check("lu_issue", Out_valid, 1);
    check("lu_a", RF_A, 32'h6);
    RF_WrEn = 1'b0; RF_WrData_sel = 1'b0; MEM_out = 32'h0;

    Instr = mki(6'h00, 5'd1, 5'd6, 16'h1234);
    step();
    Stall_in = 1'b1; Instr = mki(6'h00, 5'd3, 5'd7, 16'h5678);
    repeat (3) begin
      step();
      check("stl_stall", s_stall, 1);
      check("stl_hold", Immed, 32'h1234);
    end
    Stall_in = 1'b0;
    step();
    check("stl_cap", Immed, 32'h5678);
    check("stl_rd", Out_Rd, 7);

    // hazard under an external stall holds, then bubbles once the stall drops
    Instr = mki(6'h0F, 5'd1, 5'd3, 16'h0004);
    step();
    Instr = mk(6'h00, 5'd3, 5'd0, 5'd0); Stall_in = 1'b1;
    step();
    check("hs_hold_ld", Out_IsLoad, 1);
    Stall_in = 1'b0;
    step();
    check("hs_bubble", Out_valid, 0);
    step();
    check("hs_issue", Out_valid, 1);

    Instr = mki(6'h0F, 5'd1, 5'd3, 16'h0004);
    step();
    Instr = mk(6'h00, 5'd3, 5'd0, 5'd1); Stall_in = 1'b1; Flush = 1'b1;
    step();
    check("fl_stall", s_stall, 0);
    check("fl_valid", Out_valid, 0);
    check("fl_immed", Immed, 0);
    check("fl_a", RF_A, 0);
    check("fl_b", RF_B, 0);
    Stall_in = 1'b0; Flush = 1'b0;

    Instr = mk(6'h00, 5'd0, 5'd1, 5'd0);
    RF_WrEn = 1'b1; Wb_Addr = 5'd0; ALU_out = 32'hFFFFFFFF;
    step();
    check("r0_byp_a", RF_A, 0);
    check("r0_byp_b", RF_B, 0);
    RF_WrEn = 1'b0; ALU_out = 32'h0;
    step();
    check("r0_arr_a", RF_A, 0);
    RF_B_sel = 1'b1;
    step();
    check("bsel_rd", RF_B, 32'h3);
    RF_B_sel = 1'b0;

    // asynchronous reset mid-stream, with a dependent instruction behind a load
    Instr = mki(6'h0F, 5'd1, 5'd3, 16'h0044);
    step();
    Instr = mk(6'h00, 5'd3, 5'd2, 5'd1);
    Rst_n = 1'b0;
    #1;
    check_zero_outs("mrst");
    model_reset();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    step();
    check("mrst_r3", RF_A, 0);
    check("mrst_r1", RF_B, 0);
    check("mrst_valid", Out_valid, 1);

    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
